// File: rtl/conv_keyin.sv
// conv_keyin: keypad-to-fixed-point converter.
// Collects up to three integer digits and three fractional digits from a
// strobed keypad, then right-pads the fraction to thousandths before
// flagging the value as complete.
module conv_keyin (
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [9:0] deci,
    output logic [9:0] decp,
    output logic [1:0] ni,
    output logic [1:0] nf,
    output logic       complete,
    output logic       err
);

    typedef enum logic [1:0] {
        S_INT  = 2'd0,
        S_FRAC = 2'd1,
        S_PAD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [9:0] deci_reg, deci_next;
    logic [9:0] decp_reg, decp_next;
    logic [1:0] ni_reg, ni_next;
    logic [1:0] nf_reg, nf_next;
    logic       complete_reg, complete_next;
    logic       err_reg, err_next;

    logic is_digit, is_dot, is_enter, is_clear;

    // x*10 + d using shift-add in 14 bits; digit limits keep the result <= 999.
    function automatic logic [9:0] mac10(input logic [9:0] x, input logic [3:0] d);
        logic [13:0] w;
        w = {4'd0, x};
        w = (w << 3) + (w << 1) + {10'd0, d};
        return w[9:0];
    endfunction

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_dot   = key_valid && (key_code == 4'hA);
    assign is_enter = key_valid && (key_code == 4'hB);
    assign is_clear = key_valid && (key_code == 4'hC);

    assign deci     = deci_reg;
    assign decp     = decp_reg;
    assign ni       = ni_reg;
    assign nf       = nf_reg;
    assign complete = complete_reg;
    assign err      = err_reg;

    // State and datapath registers; reset wins over any key in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= S_INT;
            deci_reg     <= 10'd0;
            decp_reg     <= 10'd0;
            ni_reg       <= 2'd0;
            nf_reg       <= 2'd0;
            complete_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            deci_reg     <= deci_next;
            decp_reg     <= decp_next;
            ni_reg       <= ni_next;
            nf_reg       <= nf_next;
            complete_reg <= complete_next;
            err_reg      <= err_next;
        end
    end

    // Next-state and datapath decode; clear overrides everything, undefined codes fall through.
    always_comb begin
        state_next = state_reg;
        deci_next  = deci_reg;
        decp_next  = decp_reg;
        ni_next    = ni_reg;
        nf_next    = nf_reg;
        err_next   = 1'b0;

        if (is_clear) begin
            state_next = S_INT;
            deci_next  = 10'd0;
            decp_next  = 10'd0;
            ni_next    = 2'd0;
            nf_next    = 2'd0;
        end else begin
            case (state_reg)
                S_INT: begin
                    if (is_digit) begin
                        if (ni_reg != 2'd3) begin
                            deci_next = mac10(deci_reg, key_code);
                            ni_next   = ni_reg + 2'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (is_dot) begin
                        state_next = S_FRAC;
                    end else if (is_enter) begin
                        state_next = S_PAD;
                    end
                end
                S_FRAC: begin
                    if (is_digit) begin
                        if (nf_reg != 2'd3) begin
                            decp_next = mac10(decp_reg, key_code);
                            nf_next   = nf_reg + 2'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (is_dot) begin
                        err_next = 1'b1;
                    end else if (is_enter) begin
                        state_next = S_PAD;
                    end
                end
                S_PAD: begin
                    // Keys other than clear are ignored while padding.
                    if (nf_reg != 2'd3) begin
                        decp_next = mac10(decp_reg, 4'd0);
                        nf_next   = nf_reg + 2'd1;
                    end else begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (is_digit) begin
                        state_next = S_INT;
                        deci_next  = {6'd0, key_code};
                        ni_next    = 2'd1;
                        decp_next  = 10'd0;
                        nf_next    = 2'd0;
                    end else if (is_dot) begin
                        state_next = S_FRAC;
                        deci_next  = 10'd0;
                        decp_next  = 10'd0;
                        ni_next    = 2'd0;
                        nf_next    = 2'd0;
                    end
                end
                default: state_next = S_INT;
            endcase
        end

        complete_next = (state_next == S_DONE);
    end

endmodule

// File: doc/conv_keyin.md
CONV_KEYIN -- requirements
Module: conv_keyin

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 key_valid  input  1  one-cycle strobe; key_code sampled only when high.
REQ-005 key_code  input  4  0-9 = digit, 4'hA = decimal point, 4'hB = enter, 4'hC = clear, 4'hD-4'hF = undefined.
REQ-006 deci  output  10  integer part, binary, range 0-999.
REQ-007 decp  output  10  fractional part in thousandths, binary, range 0-999.
REQ-008 ni  output  2  integer digits entered, 0-3.
REQ-009 nf  output  2  fractional digits held, 0-3.
REQ-010 complete  output  1  level; high while a finished value is held.
REQ-011 err  output  1  one-cycle pulse on a rejected key.

Function
REQ-012 SHALL implement the states INT, FRAC, PAD and DONE; all outputs SHALL be registered.
REQ-013 Digit in INT: if ni<3, deci <= deci*10 + digit and ni++; if ni==3, no update and err pulses.
REQ-014 Dot in INT: state goes to FRAC; deci unchanged.
REQ-015 Digit in FRAC: if nf<3, decp <= decp*10 + digit and nf++; if nf==3, no update and err pulses.
REQ-016 Dot in FRAC: err pulses; no other change.
REQ-017 Enter in INT or FRAC: state goes to PAD.
REQ-018 PAD: on each clock with nf<3, decp <= decp*10 and nf++; on the clock with nf==3, state goes to DONE.
REQ-019 PAD: all keys except clear are ignored, with no err.
REQ-020 Latency: with k fractional digits at the enter edge, complete SHALL rise (3-k)+1 clocks after that edge.
REQ-021 complete SHALL equal (state==DONE).
REQ-022 Digit in DONE: start a new entry; deci <= digit, ni <= 1, decp <= 0, nf <= 0, state goes to INT.
REQ-023 Dot in DONE: deci, decp, ni and nf cleared; state goes to FRAC.
REQ-024 Enter in DONE: ignored.
REQ-025 Clear in any state, including PAD: deci, decp, ni and nf cleared; state goes to INT; err low.
REQ-026 Undefined codes 4'hD-4'hF: ignored silently in every state.
REQ-027 *10 SHALL be computed as (x<<3)+(x<<1) in at least 14 bits and stored truncated to 10 bits; the digit limits guarantee the result never exceeds 999.
REQ-028 err SHALL be high only in the cycle after the rejecting edge and low otherwise.

Reset
REQ-029 RST high at a clock edge: state goes to INT; deci=0, decp=0, ni=0, nf=0, complete=0, err=0.
REQ-030 RST SHALL take priority over any key presented in the same cycle, in every state, including mid-PAD.

Verification
REQ-031 Keys 1,2,3,enter -> deci=123, decp=0, nf=3; complete high exactly 4 clocks after the enter edge.
REQ-032 Keys 2,dot,5,enter -> deci=2, decp=500; complete high 3 clocks after the enter edge.
REQ-033 Keys 1,2,3,4 -> deci=123, ni=3; err pulses once, one cycle after the 4th digit.
REQ-034 Keys dot,dot,7,enter -> err pulse on the 2nd dot; deci=0, decp=700; complete high.
REQ-035 Keys 9,enter, then digit 5 during PAD -> 5 ignored; DONE reached with deci=9; a following digit 4 gives deci=4, ni=1, complete low.
REQ-036 Keys 4,dot,6, then RST (or clear) with a simultaneous digit key -> all outputs zero, state INT; the digit is not applied.
